// File: rtl/traceback_unit.sv
// Needleman-Wunsch traceback: walks the direction matrix from (N,N) to (0,0) and
// streams one alignment op per step on a valid/ready interface.
module traceback_unit #(
  parameter int N       = 5,
  parameter int BitAddr = $clog2(N+1),
  parameter int RD_LAT  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               en_traceB,
  output logic [BitAddr:0]   i_t,
  output logic [BitAddr:0]   j_t,
  input  logic [2:0]         symbol_out,
  output logic               op_valid,
  input  logic               op_ready,
  output logic [1:0]         op_code,
  output logic [BitAddr:0]   op_i,
  output logic [BitAddr:0]   op_j,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [BitAddr+1:0] len
);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_WAIT, S_EMIT, S_DONE, S_ERR
  } state_e;

  localparam logic [1:0] OP_DIAG = 2'b00;
  localparam logic [1:0] OP_UP   = 2'b01;
  localparam logic [1:0] OP_LEFT = 2'b10;
  localparam int         CW      = $clog2(RD_LAT+1);

  localparam logic [BitAddr:0]   IDX_N   = (BitAddr+1)'(N);
  localparam logic [BitAddr+1:0] LEN_MAX = (BitAddr+2)'(2*N);
  localparam logic [CW-1:0]      WAIT_LAST = CW'(RD_LAT);

  state_e               state_q, state_d;
  logic [BitAddr:0]     i_q, i_d, j_q, j_d;
  logic [BitAddr:0]     it_q, it_d, jt_q, jt_d;
  logic [BitAddr+1:0]   len_q, len_d;
  logic [1:0]           code_q, code_d;
  logic [CW-1:0]        wcnt_q, wcnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      it_q    <= '0;
      jt_q    <= '0;
      len_q   <= '0;
      code_q  <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      it_q    <= it_d;
      jt_q    <= jt_d;
      len_q   <= len_d;
      code_q  <= code_d;
      wcnt_q  <= wcnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    it_d      = it_q;
    jt_d      = jt_q;
    len_d     = len_q;
    code_d    = code_q;
    wcnt_d    = wcnt_q;
    en_traceB = 1'b0;
    done      = 1'b0;
    // RAM address is live only in the READ cycle; otherwise the last address is held
    i_t       = it_q;
    j_t       = jt_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          i_d     = IDX_N;
          j_d     = IDX_N;
          len_d   = '0;
          state_d = S_READ;
        end
      end
      S_READ: begin
        if (i_q == '0 && j_q == '0) begin
          done    = 1'b1;
          state_d = S_DONE;
        end else if (i_q == '0) begin
          code_d  = OP_LEFT;
          state_d = S_EMIT;
        end else if (j_q == '0) begin
          code_d  = OP_UP;
          state_d = S_EMIT;
        end else begin
          en_traceB = 1'b1;
          i_t       = i_q;
          j_t       = j_q;
          it_d      = i_q;
          jt_d      = j_q;
          wcnt_d    = CW'(1);
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (wcnt_q == WAIT_LAST) begin
          case (symbol_out)
            3'b100:  begin code_d = OP_DIAG; state_d = S_EMIT; end
            3'b010:  begin code_d = OP_UP;   state_d = S_EMIT; end
            3'b001:  begin code_d = OP_LEFT; state_d = S_EMIT; end
            default: state_d = S_ERR;
          endcase
        end else begin
          wcnt_d = wcnt_q + CW'(1);
        end
      end
      S_EMIT: begin
        if (op_ready) begin
          // guard against a corrupted matrix producing an over-long path
          if (len_q == LEN_MAX) begin
            state_d = S_ERR;
          end else begin
            len_d   = len_q + 1'b1;
            state_d = S_READ;
            if (code_q != OP_LEFT) i_d = i_q - 1'b1;
            if (code_q != OP_UP)   j_d = j_q - 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign op_valid = (state_q == S_EMIT);
  assign op_code  = code_q;
  assign op_i     = i_q;
  assign op_j     = j_q;
  assign busy     = (state_q == S_READ) || (state_q == S_WAIT) || (state_q == S_EMIT);
  assign err      = (state_q == S_ERR);
  assign len      = len_q;

endmodule

// File: tb/tb_traceback_unit.sv
// Bench for traceback_unit: table of matrix patterns checked against a path-walking
// reference model, plus stall, error-recovery and mid-run reset sequences.
module tb_traceback_unit;
  localparam int N = 5;
  localparam int BA = $clog2(N+1);
  localparam int RD_LAT = 1;

  logic          clk = 1'b0;
  logic          rst, start;
  logic          en_traceB;
  logic [BA:0]   i_t, j_t;
  logic [2:0]    symbol_out;
  logic          op_valid;
  logic          op_ready = 1'b0;
  logic [1:0]    op_code;
  logic [BA:0]   op_i, op_j;
  logic          busy, done, err;
  logic [BA+1:0] len;

  always #5 clk = ~clk;

  traceback_unit #(.N(N), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .en_traceB(en_traceB), .i_t(i_t), .j_t(j_t),
    .symbol_out(symbol_out), .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
    .op_i(op_i), .op_j(op_j), .busy(busy), .done(done), .err(err), .len(len)
  );

  // direction RAM model with RD_LAT cycle read latency
  logic [2:0] mem [0:N][0:N];
  logic [2:0] rd_pipe [RD_LAT];
  always @(posedge clk) begin
    if (en_traceB) rd_pipe[0] <= mem[i_t][j_t];
    for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign symbol_out = rd_pipe[RD_LAT-1];

  typedef struct { int i; int j; int code; } op_t;
  typedef struct { int i; int j; } rd_t;
  typedef struct { int kind; int mode; int exp_len; int exp_err; } vec_t;

  op_t exp_ops[$];
  rd_t exp_rd[$];
  int  m_len, m_err, m_cyc;
  int  checks = 0, failures = 0;
  int  rmode = 0, stall = 0, acc_cnt = 0, done_cnt = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // reference: walk from (N,N) applying the direction rules directly
  task automatic model();
    int i, j, code;
    logic [2:0] s;
    i = N; j = N;
    exp_ops.delete(); exp_rd.delete();
    m_len = 0; m_err = 0; m_cyc = 1;
    while (!(i == 0 && j == 0)) begin
      if (i == 0) begin code = 2; m_cyc += 2; end
      else if (j == 0) begin code = 1; m_cyc += 2; end
      else begin
        exp_rd.push_back('{i, j});
        s = mem[i][j];
        if ($countones(s) != 1) begin m_err = 1; break; end
        code = s[2] ? 0 : (s[1] ? 1 : 2);
        m_cyc += 2 + RD_LAT;
      end
      exp_ops.push_back('{i, j, code});
      m_len++;
      if (code != 2) i--;
      if (code != 1) j--;
    end
  endtask

  task automatic fill(input int kind);
    logic [2:0] base;
    int r;
    base = (kind == 1) ? 3'b010 : (kind == 2) ? 3'b001 : 3'b100;
    for (int a = 0; a <= N; a++)
      for (int b = 0; b <= N; b++) begin
        mem[a][b] = base;
        if (kind == 7) begin
          r = $urandom_range(0, 31);
          mem[a][b] = (r == 0) ? 3'b011 : (r == 1) ? 3'b000 : (3'b001 << (r % 3));
        end
      end
    case (kind)
      3: mem[3][3] = 3'b011;
      4: mem[5][5] = 3'b000;
      5: begin mem[5][5] = 3'b010; mem[4][5] = 3'b001; end
      6: begin mem[3][3] = 3'b010; mem[2][3] = 3'b010; mem[1][3] = 3'b010; end
      default: ;
    endcase
  endtask

  always @(posedge clk) begin
    #1;
    case (rmode)
      0: op_ready = 1'b1;
      1: op_ready = 1'($urandom_range(0, 1));
      2: if (op_valid && acc_cnt == 1 && stall < 4) begin op_ready = 1'b0; stall++; end
         else op_ready = 1'b1;
      default: op_ready = 1'b0;
    endcase
  end

  logic       hold_pend = 1'b0;
  logic [1:0] h_code;
  int         h_i, h_j, h_len;
  rd_t        r_mon;
  op_t        o_mon;
  always @(negedge clk) begin
    if (rst) hold_pend = 1'b0;
    else begin
      if (en_traceB) begin
        if (exp_rd.size() == 0) chk("rd_unexpected", 1, 0);
        else begin
          r_mon = exp_rd.pop_front();
          chk("rd_i", i_t, r_mon.i);
          chk("rd_j", j_t, r_mon.j);
        end
      end
      if (done) begin done_cnt++; chk("done_with_valid", op_valid, 0); end
      if (hold_pend) begin
        chk("hold_valid", op_valid, 1);
        chk("hold_code", op_code, h_code);
        chk("hold_i", op_i, h_i);
        chk("hold_j", op_j, h_j);
        chk("hold_len", len, h_len);
      end
      if (op_valid && op_ready) begin
        if (exp_ops.size() == 0) chk("op_unexpected", 1, 0);
        else begin
          o_mon = exp_ops.pop_front();
          chk("op_code", op_code, o_mon.code);
          chk("op_i", op_i, o_mon.i);
          chk("op_j", op_j, o_mon.j);
        end
        chk("len_before_accept", len, acc_cnt);
        acc_cnt++;
      end
      hold_pend = op_valid && !op_ready;
      h_code = op_code; h_i = op_i; h_j = op_j; h_len = len;
    end
  end

  task automatic run_case(input vec_t v);
    int cyc, exp_len, exp_err;
    fill(v.kind);
    model();
    exp_len = (v.exp_len < 0) ? m_len : v.exp_len;
    exp_err = (v.exp_err < 0) ? m_err : v.exp_err;
    rmode = v.mode; stall = 0; acc_cnt = 0; done_cnt = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        chk("busy_after_start", busy, 1);
        chk("err_cleared", err, 0);
        chk("len_restart", len, 0);
      end
    end while (!(done || err) && cyc < 2000);
    if (cyc >= 2000) chk("timeout", 1, 0);
    if (v.mode == 0 && !m_err) chk("cycles", cyc, m_cyc);
    @(negedge clk);
    chk("len_final", len, exp_len);
    chk("err_final", err, exp_err);
    chk("done_pulses", done_cnt, exp_err ? 0 : 1);
    chk("busy_final", busy, 0);
    chk("ops_left", exp_ops.size(), 0);
    chk("reads_left", exp_rd.size(), 0);
  endtask

  vec_t tbl[$];
  int   cnt;

  initial begin
    rst = 1'b1; start = 1'b0;
    fill(0);
    for (int k = 0; k < RD_LAT; k++) rd_pipe[k] = 3'b100;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_en", en_traceB, 0); chk("rst_valid", op_valid, 0);
    chk("rst_busy", busy, 0);    chk("rst_done", done, 0);
    chk("rst_err", err, 0);      chk("rst_len", len, 0);
    chk("rst_op_i", op_i, 0);    chk("rst_i_t", i_t, 0);
    @(posedge clk); #1 rst = 1'b0;

    tbl.push_back('{0, 0, 5, 0});    // all DIAG
    tbl.push_back('{5, 0, 6, 0});    // UP, LEFT, then DIAG
    tbl.push_back('{6, 0, 8, 0});    // reaches i=0 at j=3, forced LEFTs
    tbl.push_back('{0, 2, 5, 0});    // 2nd op stalled 4 cycles
    tbl.push_back('{3, 0, 2, 1});    // illegal 011 at (3,3)
    tbl.push_back('{0, 0, 5, 0});    // start after error clears err
    tbl.push_back('{1, 0, 10, 0});   // all UP then forced LEFT
    tbl.push_back('{2, 0, 10, 0});   // all LEFT then forced UP
    tbl.push_back('{4, 0, 0, 1});    // 000 at the first cell
    for (int k = 0; k < 6; k++) tbl.push_back('{7, (k < 4) ? 1 : 0, -1, -1});
    foreach (tbl[k]) run_case(tbl[k]);

    // reset while an op is stalled in EMIT
    fill(0); model();
    rmode = 0; acc_cnt = 0; stall = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cnt = 0;
    while (acc_cnt < 2 && cnt < 200) begin @(negedge clk); cnt++; end
    rmode = 3;
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (!op_valid && cnt < 200);
    chk("stalled_valid", op_valid, 1);
    chk("stalled_len", len, 2);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", op_valid, 0); chk("mid_rst_busy", busy, 0);
    chk("mid_rst_len", len, 0);        chk("mid_rst_op_i", op_i, 0);
    chk("mid_rst_op_j", op_j, 0);      chk("mid_rst_i_t", i_t, 0);
    chk("mid_rst_err", err, 0);        chk("mid_rst_en", en_traceB, 0);
    run_case('{0, 0, 5, 0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
